// File: rtl/npu_act_wr_rr_arbiter_if.sv
// Activation-memory write arbitration bundle: requester side and memory side.
// Stats outputs exist only when NPU_WR_ARB_STATS_EN is defined.
interface npu_act_wr_rr_arbiter_if #(
    parameter int NUM_REQ = 32,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack_p;
    logic                      rd_busy;
    logic                      mem_wr_en;
    logic [ADDR_W-1:0]         mem_wr_addr;
    logic [DATA_W-1:0]         mem_wr_data;
    logic [1:0]                arb_state;
    logic [4:0]                last_grant;
`ifdef NPU_WR_ARB_STATS_EN
    logic [31:0]               grant_total;
    logic [31:0]               stall_cycles;
`endif

    modport master (
        output req, req_addr, req_data, rd_busy,
        input  ack_p, mem_wr_en, mem_wr_addr, mem_wr_data,
`ifdef NPU_WR_ARB_STATS_EN
        input  grant_total, stall_cycles,
`endif
        input  arb_state, last_grant
    );

    modport slave (
        input  req, req_addr, req_data, rd_busy,
        output ack_p, mem_wr_en, mem_wr_addr, mem_wr_data,
`ifdef NPU_WR_ARB_STATS_EN
        output grant_total, stall_cycles,
`endif
        output arb_state, last_grant
    );
endinterface

// File: rtl/npu_act_wr_rr_arbiter.sv
// Round-robin arbiter for the activation-memory write port, blocked by rd_busy.
// Define NPU_WR_ARB_STATS_EN to add grant_total / stall_cycles counters.
module npu_act_wr_rr_arbiter #(
    parameter int NUM_REQ = 32,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16
) (
    input logic clk,
    input logic rst,
    npu_act_wr_rr_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, winner, idx;
    logic [PTR_W:0]   sum;
    logic             any_req, found, grant;

    assign any_req = |bus.req;
    assign grant   = any_req && !bus.rd_busy && !rst;

    // Scan ptr+1 .. ptr+NUM_REQ so the last winner gets lowest priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            idx = sum[PTR_W-1:0];
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        bus.ack_p = '0;
        if (grant)
            bus.ack_p[winner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, SERVE: begin
                if (any_req && !bus.rd_busy)
                    state_nxt = SERVE;
                else if (any_req)
                    state_nxt = STALL;
                else
                    state_nxt = IDLE;
            end
            STALL: begin
                if (!any_req)
                    state_nxt = IDLE;
                else if (!bus.rd_busy)
                    state_nxt = SERVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.arb_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= PTR_W'(NUM_REQ - 1);
            bus.last_grant  <= '0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_addr <= '0;
            bus.mem_wr_data <= '0;
        end else begin
            state         <= state_nxt;
            bus.mem_wr_en <= grant;
            if (grant) begin
                ptr             <= winner;
                bus.last_grant  <= 5'(winner);
                bus.mem_wr_addr <= bus.req_addr[ADDR_W*int'(winner) +: ADDR_W];
                bus.mem_wr_data <= bus.req_data[DATA_W*int'(winner) +: DATA_W];
            end
        end
    end

`ifdef NPU_WR_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.grant_total  <= '0;
            bus.stall_cycles <= '0;
        end else begin
            if (grant && bus.grant_total != '1)
                bus.grant_total <= bus.grant_total + 32'd1;
            if (any_req && bus.rd_busy && bus.stall_cycles != '1)
                bus.stall_cycles <= bus.stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_npu_act_wr_rr_arbiter.sv
// Directed bench for the round-robin activation write arbiter.
// Inputs change 1 time unit after posedge; outputs are sampled before the next edge.
module tb_npu_act_wr_rr_arbiter;
    localparam int N  = 32;
    localparam int AW = 14;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    int   tests  = 0;
    int   failed = 0;
    int   cnt [N];

    always #5 clk = ~clk;

    npu_act_wr_rr_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    npu_act_wr_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] e;
        rst         = 1'b1;
        bus.req     = '0;
        bus.rd_busy = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[AW*i +: AW] = AW'(14'h100 + i);
            bus.req_data[DW*i +: DW] = DW'(16'hA000 + i);
            cnt[i] = 0;
        end
        bus.req = 32'h5;
        tick();
        tick();
        check("rst_ack", 64'(bus.ack_p), 64'h0);
        check("rst_en", 64'(bus.mem_wr_en), 64'h0);
        check("rst_addr", 64'(bus.mem_wr_addr), 64'h0);
        check("rst_data", 64'(bus.mem_wr_data), 64'h0);
        check("rst_state", 64'(bus.arb_state), 64'h0);
        check("rst_last", 64'(bus.last_grant), 64'h0);

        rst = 1'b0;
        #1;
        check("t1_ack0", 64'(bus.ack_p), 64'h1);
        tick();
        check("t1_en0", 64'(bus.mem_wr_en), 64'h1);
        check("t1_addr0", 64'(bus.mem_wr_addr), 64'h100);
        check("t1_data0", 64'(bus.mem_wr_data), 64'hA000);
        check("t1_state", 64'(bus.arb_state), 64'h1);
        check("t1_ack1", 64'(bus.ack_p), 64'h4);
        tick();
        check("t1_en1", 64'(bus.mem_wr_en), 64'h1);
        check("t1_addr1", 64'(bus.mem_wr_addr), 64'h102);
        check("t1_data1", 64'(bus.mem_wr_data), 64'hA002);
        check("t1_last", 64'(bus.last_grant), 64'h2);
        bus.req = '0;
        #1;
        check("t1_ack_none", 64'(bus.ack_p), 64'h0);
        tick();
        check("t1_en_off", 64'(bus.mem_wr_en), 64'h0);
        check("t1_addr_hold", 64'(bus.mem_wr_addr), 64'h102);
        check("t1_idle", 64'(bus.arb_state), 64'h0);

        bus.req_addr[AW*7 +: AW] = 14'h0123;
        bus.req_data[DW*7 +: DW] = 16'h0A5A;
        bus.req = 32'h80;
        #1;
        check("t2_ack", 64'(bus.ack_p), 64'h80);
        tick();
        bus.req = '0;
        check("t2_en", 64'(bus.mem_wr_en), 64'h1);
        check("t2_addr", 64'(bus.mem_wr_addr), 64'h0123);
        check("t2_data", 64'(bus.mem_wr_data), 64'h0A5A);
        check("t2_last", 64'(bus.last_grant), 64'h7);

        rst = 1'b1;
        tick();
        rst = 1'b0;

        bus.req     = 32'h3;
        bus.rd_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_ack_blk", 64'(bus.ack_p), 64'h0);
            tick();
            check("t4_stall", 64'(bus.arb_state), 64'h2);
            check("t4_en_off", 64'(bus.mem_wr_en), 64'h0);
        end
        bus.rd_busy = 1'b0;
        #1;
        check("t4_ack0", 64'(bus.ack_p), 64'h1);
        tick();
        check("t4_en0", 64'(bus.mem_wr_en), 64'h1);
        check("t4_addr0", 64'(bus.mem_wr_addr), 64'h100);
        check("t4_serve", 64'(bus.arb_state), 64'h1);
        bus.req = 32'h2;
        #1;
        check("t4_ack1", 64'(bus.ack_p), 64'h2);
        tick();
        bus.req = '0;
        check("t4_addr1", 64'(bus.mem_wr_addr), 64'h101);
        check("t4_last1", 64'(bus.last_grant), 64'h1);
`ifdef NPU_WR_ARB_STATS_EN
        check("t4_stall_cnt", 64'(bus.stall_cycles), 64'd5);
        check("t4_grant_cnt", 64'(bus.grant_total), 64'd2);
`endif

        rst = 1'b1;
        tick();
        rst = 1'b0;

        bus.req = '1;
        for (int k = 0; k < 64; k++) begin
            #1;
            e = 32'h1 << (k % 32);
            check("t3_ack", 64'(bus.ack_p), 64'(e));
            for (int j = 0; j < N; j++)
                if (bus.ack_p[j]) cnt[j]++;
            tick();
            check("t3_en", 64'(bus.mem_wr_en), 64'h1);
            check("t3_last", 64'(bus.last_grant), 64'(k % 32));
        end
        for (int j = 0; j < N; j++)
            check("t3_cnt", 64'(cnt[j]), 64'd2);

        bus.req = 32'h8000_0001;
        #1;
        check("t5_wrap_ack", 64'(bus.ack_p), 64'h1);
        tick();
        check("t5_wrap_last", 64'(bus.last_grant), 64'h0);
        #1;
        check("t5_ack31", 64'(bus.ack_p), 64'h8000_0000);
        tick();
        check("t5_en31", 64'(bus.mem_wr_en), 64'h1);
        check("t5_last31", 64'(bus.last_grant), 64'd31);
        check("t5_addr31", 64'(bus.mem_wr_addr), 64'h11F);
        rst = 1'b1;
        #1;
        check("t5_rst_en", 64'(bus.mem_wr_en), 64'h0);
        check("t5_rst_ack", 64'(bus.ack_p), 64'h0);
        check("t5_rst_state", 64'(bus.arb_state), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_post_ack", 64'(bus.ack_p), 64'h1);
        tick();
        check("t5_post_last", 64'(bus.last_grant), 64'h0);
        check("t5_post_en", 64'(bus.mem_wr_en), 64'h1);
        bus.req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
